io_read_ports: RTL and testbench

Read-side I/O port block for an operand fetch path: the counterpart of the I/O write-port logic. It decodes the raw read address from the instruction (Stage 1) and reports the selected port's Full bit for thread issue control. For an address inside the read-port window, it issues a one-cycle read strobe to that port and captures its word. The captured word is then merged with RAM read data, so the operand leaves the block aligned to a plain RAM read.

---
 rtl/io_read_ports.sv | 178 +++++++++++++++++
 tb/tb_io_read_ports.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_read_ports.sv
`default_nettype none
// ============================================================================
//  Module      : io_read_ports
//  Description : Read-side I/O port block of the operand fetch path.
//                Decodes the raw read address, reports the selected port's
//                Full bit, strobes the selected port one cycle later, captures
//                its word and merges it with RAM read data. The merged operand
//                leaves with the same timing as a plain RAM read plus one
//                output register.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   single clock, all state on rising edge
//    reset_n      in   asynchronous active-low reset
//    addr_raw     in   read address from raw instruction (cycle 0)
//    full         in   per-port Full bit (1 = port holds an unread word)
//    data_in      in   port words, port i at [i*WORD_WIDTH +: WORD_WIDTH]
//    IO_ready     in   cycle 1: the thread's instruction proceeds
//    data_RAM     in   RAM read data for the same instruction (cycle 2)
//    full_masked  out  cycle 0: selected Full bit, 1 for non-I/O addresses
//    rden         out  cycle 1: one-hot read strobe to the selected port
//    read_is_IO   out  cycle 3: operand came from a non-annulled I/O read
//    data_out     out  cycle 3: merged operand
// ============================================================================
module io_read_ports #(
    parameter int WORD_WIDTH           = 36,
    parameter int ADDR_WIDTH           = 10,
    parameter int READ_PORT_COUNT      = 8,
    parameter int READ_PORT_BASE_ADDR  = 1016,
    parameter int READ_PORT_ADDR_WIDTH = 3
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [ADDR_WIDTH-1:0]                 addr_raw,
    input  logic [READ_PORT_COUNT-1:0]            full,
    input  logic [READ_PORT_COUNT*WORD_WIDTH-1:0] data_in,
    input  logic                                  IO_ready,
    input  logic [WORD_WIDTH-1:0]                 data_RAM,
    output logic                                  full_masked,
    output logic [READ_PORT_COUNT-1:0]            rden,
    output logic                                  read_is_IO,
    output logic [WORD_WIDTH-1:0]                 data_out
);

    // Number of index values the port index can express; ports beyond
    // READ_PORT_COUNT read back as zero so every index lookup stays in range.
    localparam int c_slots = 2 ** READ_PORT_ADDR_WIDTH;

    // The window is compared one bit wider than the address so that a window
    // reaching the top of the address space (or past it) cannot wrap around
    // to address 0. Ports that would sit beyond the top address are simply
    // unreachable.
    localparam logic [ADDR_WIDTH:0] c_base_ext =
        (ADDR_WIDTH+1)'(READ_PORT_BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] c_end_ext =
        (ADDR_WIDTH+1)'(READ_PORT_BASE_ADDR + READ_PORT_COUNT);

    // Low bits of the base: the truncated difference of the full values equals
    // the difference of their truncated low bits.
    localparam logic [READ_PORT_ADDR_WIDTH-1:0] c_base_lo =
        READ_PORT_ADDR_WIDTH'(READ_PORT_BASE_ADDR);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    generate
        if ((READ_PORT_COUNT < 1) ||
            (READ_PORT_ADDR_WIDTH < 1) ||
            (READ_PORT_ADDR_WIDTH > ADDR_WIDTH) ||
            (c_slots < READ_PORT_COUNT)) begin : g_bad_params
            $error("io_read_ports: inconsistent port count / index width");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Port vectors padded to the full index range
    // ------------------------------------------------------------------
    logic [c_slots-1:0]    w_full_pad;
    logic [WORD_WIDTH-1:0] w_word [c_slots];

    generate
        for (genvar gi = 0; gi < c_slots; gi++) begin : g_pad
            if (gi < READ_PORT_COUNT) begin : g_port
                assign w_full_pad[gi] = full[gi];
                assign w_word[gi]     = data_in[gi*WORD_WIDTH +: WORD_WIDTH];
            end else begin : g_empty
                assign w_full_pad[gi] = 1'b0;
                assign w_word[gi]     = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Cycle 0: address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0]             w_addr_ext;
    logic                            w_in_range;
    logic [READ_PORT_ADDR_WIDTH-1:0] w_idx;

    always_comb begin
        w_addr_ext  = {1'b0, addr_raw};
        w_in_range  = (w_addr_ext >= c_base_ext) && (w_addr_ext < c_end_ext);
        w_idx       = addr_raw[READ_PORT_ADDR_WIDTH-1:0] - c_base_lo;
        // Non-I/O addresses report "full" so they never hold back issue.
        full_masked = w_in_range ? w_full_pad[w_idx] : 1'b1;
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                            is_io_q,      is_io_d;
    logic [READ_PORT_ADDR_WIDTH-1:0] idx_q,        idx_d;
    logic [WORD_WIDTH-1:0]           io_word_q,    io_word_d;
    logic                            io_valid_q,   io_valid_d;
    logic                            is_io_dly_q,  is_io_dly_d;
    logic [WORD_WIDTH-1:0]           data_out_q,   data_out_d;
    logic                            read_is_io_q, read_is_io_d;

    always_comb begin
        // Stage 1: decoded address
        is_io_d      = w_in_range;
        idx_d        = w_idx;

        // End of cycle 1: capture the selected port's word. The word is taken
        // unconditionally; io_valid decides whether it is used.
        io_word_d    = w_word[idx_q];
        io_valid_d   = is_io_q & IO_ready;
        is_io_dly_d  = is_io_q;

        // End of cycle 2: merge. An I/O read that was annulled (IO_ready low)
        // yields zero rather than whatever the RAM returned for that address.
        if (io_valid_q) begin
            data_out_d = io_word_q;
        end else if (is_io_dly_q) begin
            data_out_d = '0;
        end else begin
            data_out_d = data_RAM;
        end
        read_is_io_d = io_valid_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_io_q      <= 1'b0;
            idx_q        <= '0;
            io_word_q    <= '0;
            io_valid_q   <= 1'b0;
            is_io_dly_q  <= 1'b0;
            data_out_q   <= '0;
            read_is_io_q <= 1'b0;
        end else begin
            is_io_q      <= is_io_d;
            idx_q        <= idx_d;
            io_word_q    <= io_word_d;
            io_valid_q   <= io_valid_d;
            is_io_dly_q  <= is_io_dly_d;
            data_out_q   <= data_out_d;
            read_is_io_q <= read_is_io_d;
        end
    end

    // ------------------------------------------------------------------
    // Cycle 1: read strobe. Purely from registered state plus IO_ready, so
    // it is low throughout reset (is_io_q is cleared) and the Full bit is
    // deliberately not consulted again here.
    // ------------------------------------------------------------------
    generate
        for (genvar gp = 0; gp < READ_PORT_COUNT; gp++) begin : g_rden
            assign rden[gp] = is_io_q & IO_ready &
                              (idx_q == READ_PORT_ADDR_WIDTH'(gp));
        end
    endgenerate

    assign data_out   = data_out_q;
    assign read_is_IO = read_is_io_q;

endmodule
`default_nettype wire

// File: tb/tb_io_read_ports.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_read_ports
//  Description : Scoreboard bench for io_read_ports. A driver issues directed
//                read slots; a monitor compares each pipeline stage's outputs
//                against expectations queued at issue time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_read_ports;

    localparam int W  = 36;
    localparam int AW = 10;
    localparam int N  = 8;

    logic            clock;
    logic            reset_n;
    logic [AW-1:0]   addr_raw;
    logic [N-1:0]    full;
    logic [N*W-1:0]  data_in;
    logic            IO_ready;
    logic [W-1:0]    data_RAM;
    logic            full_masked;
    logic [N-1:0]    rden;
    logic            read_is_IO;
    logic [W-1:0]    data_out;

    io_read_ports #(
        .WORD_WIDTH           (W),
        .ADDR_WIDTH           (AW),
        .READ_PORT_COUNT      (N),
        .READ_PORT_BASE_ADDR  (1016),
        .READ_PORT_ADDR_WIDTH (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .addr_raw    (addr_raw),
        .full        (full),
        .data_in     (data_in),
        .IO_ready    (IO_ready),
        .data_RAM    (data_RAM),
        .full_masked (full_masked),
        .rden        (rden),
        .read_is_IO  (read_is_IO),
        .data_out    (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Directed slot table with hand-computed expectations
    int           s_addr [32];
    logic [N-1:0] s_full [32];
    logic         s_rdy  [32];
    logic [W-1:0] s_ram  [32];
    logic         s_fm   [32];
    logic [N-1:0] s_rden [32];
    logic [W-1:0] s_dout [32];
    logic         s_rio  [32];
    int           n_slots = 0;

    // Scoreboard queues
    logic         q_fm   [$];
    logic [N-1:0] q_rden [$];
    logic [W:0]   q_out  [$];

    // Slot index occupying each stage (-1 = none)
    int p0 = -1, p1 = -1, p2 = -1, p3 = -1;
    bit mon_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic         e_fm;
    logic [N-1:0] e_rden;
    logic [W:0]   e_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input int a, input logic [N-1:0] f, input logic r, input logic [W-1:0] ram,
                       input logic fm, input logic [N-1:0] rd, input logic [W-1:0] dout, input logic rio);
        s_addr[n_slots] = a;  s_full[n_slots] = f;  s_rdy[n_slots]  = r;  s_ram[n_slots] = ram;
        s_fm[n_slots]   = fm; s_rden[n_slots] = rd; s_dout[n_slots] = dout; s_rio[n_slots] = rio;
        n_slots++;
    endtask

    // One clock cycle: present slot s (or idle when s < 0) and advance stages.
    task automatic cycle(input int s);
        @(posedge clock);
        #1;
        p3 = p2; p2 = p1; p1 = p0; p0 = s;
        if (s >= 0) begin
            addr_raw = AW'(s_addr[s]);
            full     = s_full[s];
            q_fm.push_back(s_fm[s]);
            q_rden.push_back(s_rden[s]);
            q_out.push_back({s_rio[s], s_dout[s]});
        end else begin
            addr_raw = AW'(5);
            full     = '0;
        end
        IO_ready = (p1 >= 0) ? s_rdy[p1] : 1'b1;
        data_RAM = (p2 >= 0) ? s_ram[p2] : 36'h000000FFF;
    endtask

    // Monitor: compare each stage's outputs mid-cycle
    always @(negedge clock) begin
        if (mon_en) begin
            if (p0 >= 0) begin
                if (q_fm.size() == 0) check("fm_queue", 64'(q_fm.size()), 64'd1);
                else begin
                    e_fm = q_fm.pop_front();
                    check("full_masked", 64'(full_masked), 64'(e_fm));
                end
            end
            if (p1 >= 0) begin
                if (q_rden.size() == 0) check("rden_queue", 64'(q_rden.size()), 64'd1);
                else begin
                    e_rden = q_rden.pop_front();
                    check("rden", 64'(rden), 64'(e_rden));
                end
            end else begin
                check("rden_idle", 64'(rden), 64'd0);
            end
            if (p3 >= 0) begin
                if (q_out.size() == 0) check("out_queue", 64'(q_out.size()), 64'd1);
                else begin
                    e_out = q_out.pop_front();
                    check("data_out", 64'(data_out), 64'(e_out[W-1:0]));
                    check("read_is_IO", 64'(read_is_IO), 64'(e_out[W]));
                end
            end
        end
    end

    initial begin
        // Port words (constant for the whole run)
        for (int i = 0; i < N; i++) data_in[i*W +: W] = 36'h0C0DE0000 + 36'(i);
        data_in[0*W +: W] = 36'hA5A5A5A50;
        data_in[2*W +: W] = 36'h123456789;
        data_in[7*W +: W] = 36'h7F7F7F7F7;

        //   addr  full    rdy   ram          fm    rden    data_out        rio
        add(1018, 8'h04, 1'b1, 36'h0,       1'b1, 8'h04, 36'h123456789, 1'b1); // 0 single read
        add(1019, 8'hF7, 1'b0, 36'hABC,     1'b0, 8'h00, 36'h0,         1'b0); // 1 annulled
        add(5,    8'h00, 1'b1, 36'hABC,     1'b1, 8'h00, 36'hABC,       1'b0); // 2 RAM pass
        add(1015, 8'hFF, 1'b1, 36'h111,     1'b1, 8'h00, 36'h111,       1'b0); // 3 below window
        add(1016, 8'hFE, 1'b1, 36'h222,     1'b0, 8'h01, 36'hA5A5A5A50, 1'b1); // 4 first port
        add(1023, 8'h80, 1'b1, 36'h333,     1'b1, 8'h80, 36'h7F7F7F7F7, 1'b1); // 5 top address
        add(0,    8'hFF, 1'b1, 36'h444,     1'b1, 8'h00, 36'h444,       1'b0); // 6 no wrap
        add(1016, 8'h01, 1'b1, 36'h500,     1'b1, 8'h01, 36'hA5A5A5A50, 1'b1); // 7 streaming
        add(7,    8'h01, 1'b1, 36'h501,     1'b1, 8'h00, 36'h501,       1'b0); // 8
        add(1016, 8'h01, 1'b1, 36'h502,     1'b1, 8'h01, 36'hA5A5A5A50, 1'b1); // 9
        add(7,    8'h01, 1'b1, 36'h503,     1'b1, 8'h00, 36'h503,       1'b0); // 10
        add(1016, 8'h01, 1'b1, 36'h504,     1'b1, 8'h01, 36'hA5A5A5A50, 1'b1); // 11
        add(1016, 8'h00, 1'b1, 36'h505,     1'b0, 8'h01, 36'hA5A5A5A50, 1'b1); // 12 back-to-back
        add(1016, 8'h00, 1'b0, 36'h506,     1'b0, 8'h00, 36'h0,         1'b0); // 13 annulled
        add(7,    8'h00, 1'b0, 36'h507,     1'b1, 8'h00, 36'h507,       1'b0); // 14 non-I/O, not ready
        add(1020, 8'h10, 1'b1, 36'h508,     1'b1, 8'h10, 36'h0C0DE0004, 1'b1); // 15 mid port
        add(1016, 8'hFF, 1'b1, 36'h0,       1'b1, 8'h01, 36'hA5A5A5A50, 1'b1); // 16 killed by reset
        add(1016, 8'h01, 1'b1, 36'h0,       1'b1, 8'h01, 36'hA5A5A5A50, 1'b1); // 17 after release

        // Reset held with an I/O address and all ports full
        reset_n  = 1'b0;
        addr_raw = AW'(1016);
        full     = '1;
        IO_ready = 1'b1;
        data_RAM = 36'hABC;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rden",       64'(rden),        64'd0);
        check("rst_data_out",   64'(data_out),    64'd0);
        check("rst_read_is_IO", 64'(read_is_IO),  64'd0);
        check("rst_full_masked",64'(full_masked), 64'd1);
        @(posedge clock);
        #1;
        addr_raw = AW'(5);
        full     = '0;
        reset_n  = 1'b1;
        mon_en   = 1'b1;

        // Directed and streaming slots, back-to-back
        for (int s = 0; s < 16; s++) cycle(s);
        repeat (4) cycle(-1);

        // Reset in the middle of an I/O read
        mon_en = 1'b0;
        cycle(16);
        cycle(-1);
        #1;
        check("pre_reset_rden", 64'(rden), 64'h01);
        reset_n = 1'b0;
        #1;
        check("async_rden",       64'(rden),       64'd0);
        check("async_data_out",   64'(data_out),   64'd0);
        check("async_read_is_IO", 64'(read_is_IO), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        q_fm.delete();
        q_rden.delete();
        q_out.delete();
        p0 = -1; p1 = -1; p2 = -1; p3 = -1;
        addr_raw = AW'(5);
        full     = '0;
        IO_ready = 1'b1;
        reset_n  = 1'b1;
        mon_en   = 1'b1;
        cycle(17);
        repeat (4) cycle(-1);

        check("scoreboard_drained", 64'(q_out.size() + q_rden.size() + q_fm.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
